// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and defaults for pipeline stage buffers
package pipe_pkg;

  localparam int PIPE_DW_DEFAULT = 104;

  // Encoding equals the number of held words, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - enabled storage register with async reset and sync clear
module pipe_entry #(
  parameter int W = 105
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear takes priority over load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - two-entry skid buffer between pipeline stages with flush
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DW           = PIPE_DW_DEFAULT,
  parameter int CLR_ON_FLUSH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_we,
  input  logic          flush,
  output logic [1:0]    occ
);

  localparam logic CLR = (CLR_ON_FLUSH != 0);

  buf_state_t  state_q;
  buf_state_t  state_d;
  logic        out_valid_q;
  logic        in_ready_q;
  logic        accept;
  logic        pop;
  logic        head_en;
  logic        skid_en;
  logic        entry_clr;
  logic [DW:0] head_d;
  logic [DW:0] head_q;
  logic [DW:0] skid_q;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !pop) state_d = ST_TWO;
          else if (!accept && pop) state_d = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Ready/valid are registered from the next state so in_ready has no path from out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_TWO);
    end
  end

  // Head takes the incoming word when empty or being vacated, or the skid word when full and popping.
  always_comb begin
    head_en = 1'b0;
    skid_en = 1'b0;
    head_d  = {in_we, in_data};
    if (!flush) begin
      unique case (state_q)
        ST_EMPTY: head_en = accept;
        ST_ONE: begin
          head_en = accept && pop;
          skid_en = accept && !pop;
        end
        ST_TWO: begin
          head_en = pop;
          head_d  = skid_q;
        end
        default: ;
      endcase
    end
  end

  assign entry_clr = flush & CLR;

  pipe_entry #(.W(DW + 1)) u_head (
    .clk (clk),
    .rst (rst),
    .en  (head_en),
    .clr (entry_clr),
    .d   (head_d),
    .q   (head_q)
  );

  pipe_entry #(.W(DW + 1)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .clr (entry_clr),
    .d   ({in_we, in_data}),
    .q   (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q[DW-1:0];
  assign out_we    = head_q[DW] & out_valid_q;
  assign occ       = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf against a queue model
module tb_pipe_stage_buf;

  localparam int DW = 104;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_we;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_we;
  logic          flush;
  logic [1:0]    occ;

  int checks = 0;
  int errors = 0;
  word_t mq[$];

  pipe_stage_buf #(.DW(DW), .CLR_ON_FLUSH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_we     (in_we),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_we    (out_we),
    .flush     (flush),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Compare every output against the model queue: head is mq[0], ready when fewer than two held.
  task automatic compare(input string tag);
    logic exp_valid;
    exp_valid = (mq.size() != 0);
    check({tag, ":out_valid"}, 128'(out_valid), 128'(exp_valid));
    check({tag, ":in_ready"}, 128'(in_ready), 128'(mq.size() != 2));
    check({tag, ":occ"}, 128'(occ), 128'(mq.size()));
    check({tag, ":out_we"}, 128'(out_we), 128'(exp_valid ? mq[0].we : 1'b0));
    if (exp_valid) check({tag, ":out_data"}, 128'(out_data), 128'(mq[0].data));
  endtask

  task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                      input logic we, input logic ordy, input logic fl);
    bit acc;
    bit pop;
    word_t w;
    in_valid  = v;
    in_data   = d;
    in_we     = we;
    out_ready = ordy;
    flush     = fl;
    acc = v && (mq.size() != 2);
    pop = ordy && (mq.size() != 0);
    w.we   = we;
    w.data = d;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(w);
    end
    compare(tag);
  endtask

  initial begin
    logic [DW-1:0] wa;
    logic [DW-1:0] wb;
    logic [DW-1:0] wc;
    logic [DW-1:0] wab;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_we = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    #12;
    check("rst:out_valid", 128'(out_valid), 128'(0));
    check("rst:out_we", 128'(out_we), 128'(0));
    check("rst:out_data", 128'(out_data), 128'(0));
    check("rst:occ", 128'(occ), 128'(0));
    check("rst:in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;

    // Single word, one-cycle latency, then bubble.
    wab = {13{8'hAB}};
    step("single", 1'b1, wab, 1'b1, 1'b1, 1'b0);
    check("single:data", 128'(out_data), 128'(wab));
    check("single:we", 128'(out_we), 128'(1));
    step("single_gap", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("single_gap:valid", 128'(out_valid), 128'(0));

    // Back-pressure: A and B held, C refused, then drain with no gap.
    wa = rand_word();
    wb = rand_word();
    wc = rand_word();
    step("bp_a", 1'b1, wa, 1'b1, 1'b0, 1'b0);
    step("bp_b", 1'b1, wb, 1'b0, 1'b0, 1'b0);
    check("bp:occ2", 128'(occ), 128'(2));
    check("bp:in_ready0", 128'(in_ready), 128'(0));
    step("bp_c_refused", 1'b1, wc, 1'b1, 1'b0, 1'b0);
    check("bp:hold_a", 128'(out_data), 128'(wa));
    step("bp_pop_a", 1'b1, wc, 1'b1, 1'b1, 1'b0);
    check("bp:head_b", 128'(out_data), 128'(wb));
    step("bp_pop_b", 1'b1, wc, 1'b1, 1'b1, 1'b0);
    check("bp:head_c", 128'(out_data), 128'(wc));
    step("bp_pop_c", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Flush while full with a word offered: the offered word must never appear.
    step("fl_a", 1'b1, wa, 1'b1, 1'b0, 1'b0);
    step("fl_b", 1'b1, wb, 1'b1, 1'b0, 1'b0);
    step("fl_kill", 1'b1, wc, 1'b1, 1'b1, 1'b1);
    check("fl:occ0", 128'(occ), 128'(0));
    check("fl:in_ready1", 128'(in_ready), 128'(1));
    check("fl:data_cleared", 128'(out_data), 128'(0));
    step("fl_after", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Full-throughput stream.
    for (int i = 0; i < 100; i++) begin
      step("stream", 1'b1, rand_word(), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      check("stream:occ_le1", 128'(occ <= 2'd1), 128'(1));
    end
    step("stream_end", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Bubbles with in_we driven high must never show out_we.
    for (int i = 0; i < 30; i++) begin
      step("gaps", 1'($urandom_range(0, 1)), rand_word(), 1'b1, 1'b1, 1'b0);
    end

    // Random mix of back-pressure, gaps and occasional flush.
    for (int i = 0; i < 300; i++) begin
      step("mix", 1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-cycle while full.
    step("ar_a", 1'b1, wa, 1'b1, 1'b0, 1'b0);
    step("ar_b", 1'b1, wb, 1'b1, 1'b0, 1'b0);
    check("ar:occ2", 128'(occ), 128'(2));
    #3;
    rst = 1'b1;
    #1;
    check("ar:out_valid", 128'(out_valid), 128'(0));
    check("ar:out_we", 128'(out_we), 128'(0));
    check("ar:out_data", 128'(out_data), 128'(0));
    check("ar:occ", 128'(occ), 128'(0));
    check("ar:in_ready", 128'(in_ready), 128'(1));
    mq.delete();
    #2;
    rst = 1'b0;
    step("ar_after", 1'b1, wc, 1'b1, 1'b1, 1'b0);
    step("ar_after2", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DW, default 104, payload width in bits (legal range 1..256).
REQ-002 SHALL have parameter CLR_ON_FLUSH, default 1; when 1, flush also zeroes stored payload.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream presents a stage word.
REQ-006 SHALL have port in_ready, output, 1, registered; buffer can accept a word this cycle.
REQ-007 SHALL have port in_data, input, DW, upstream payload (ALU result, mem data, rd, c0 data, control bits).
REQ-008 SHALL have port in_we, input, 1, register-file write enable of the word.
REQ-009 SHALL have port out_valid, output, 1, registered; head word is valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the head word.
REQ-011 SHALL have port out_data, output, DW, registered head payload.
REQ-012 SHALL have port out_we, output, 1, equal to stored we AND out_valid (never 1 for a bubble).
REQ-013 SHALL have port flush, input, 1, synchronous kill of all held words (interrupt/exception).
REQ-014 SHALL have port occ, output, 2, number of held words (0..2).

Function
REQ-015 SHALL hold at most two words, a head register and a skid register, delivered strictly in FIFO order.
REQ-016 SHALL accept a word on a cycle where in_valid=1 and in_ready=1; it SHALL pop the head on a cycle where out_valid=1 and out_ready=1.
REQ-017 SHALL use FSM states EMPTY(occ=0), ONE(occ=1), TWO(occ=2).
REQ-018 SHALL make these transitions: EMPTY+accept->ONE; ONE+accept only->TWO; ONE+pop only->EMPTY; ONE+accept+pop->ONE; TWO+pop->ONE; all other cases hold state.
REQ-019 SHALL never accept in TWO, since in_ready=0 there.
REQ-020 SHALL give latency of exactly one cycle: a word accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 when the buffer was EMPTY or popping.
REQ-021 SHALL sustain full throughput: with out_ready held 1, one word per cycle, occ never exceeds 1.
REQ-022 SHALL set in_ready = (next state != TWO), computed from the next state and registered, so it has no combinational path from out_ready.
REQ-023 SHALL, when the skid holds a word and the head pops, move the skid into the head in the same edge, with no bubble.
REQ-024 SHALL keep out_data and out_we stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on flush=1, go to EMPTY at the next edge: out_valid=0, occ=0, in_ready=1. A simultaneous accept or pop SHALL be discarded, and flush wins.
REQ-026 SHALL zero head and skid payload and we on flush when CLR_ON_FLUSH=1; otherwise payload is retained but invalid.
REQ-027 SHALL not modify payload bits, which pass through unchanged for any DW.

Reset
REQ-028 SHALL, while rst=1, asynchronously force state EMPTY, out_valid=0, out_we=0, out_data=0, skid=0, occ=0, in_ready=1.
REQ-029 SHALL lose any words in flight when rst asserts mid-operation, and the first edge after rst deasserts SHALL behave as EMPTY.

Structure
REQ-030 SHALL place the FSM state encoding (EMPTY/ONE/TWO) and the DW default constant in shared package pipe_pkg, reused by the other stage buffers.
REQ-031 SHALL have one natural sub-module, pipe_entry (DW+1-bit enabled register with async reset and sync clear), instantiated twice for head and skid.

Verification
REQ-032 SHALL cover: reset, then in_data=0x…AB, in_we=1, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x…AB, out_we=1; following cycle out_valid=0.
REQ-033 SHALL cover: out_ready=0, send words A,B,C back-to-back -> A and B held (occ=2), in_ready=0 while C is offered; then out_ready=1 -> A, B, C emerge on consecutive cycles with no gap.
REQ-034 SHALL cover: occ=2 with flush=1 and in_valid=1 in the same cycle -> next cycle occ=0, out_valid=0, out_we=0, in_ready=1; the offered word never appears.
REQ-035 SHALL cover: stream of 100 random words with out_ready=1 -> one output per cycle, order and values match, occ≤1.
REQ-036 SHALL cover: words arriving with in_valid=0 gaps -> out_we=0 on every bubble cycle even if in_we=1 was driven.
REQ-037 SHALL cover: rst pulsed asynchronously mid-cycle with occ=2 -> outputs reach reset values before the next clk edge.
